x_rd_unpack: RTL and testbench
==============================

X_RD_UNPACK -- requirements
Module: x_rd_unpack

Interface
REQ-001 Parameter DW_OUT, default 8, width of one output slice in bits.
REQ-002 Parameter RATIO, default 4, number of slices per FIFO word; must be ≥1.
REQ-003 Derived localparam DW_IN = DW_OUT*RATIO (FIFO word width); CW = max(1, clog2(RATIO)).
REQ-004 clk  input  1  sole clock; same domain as the FIFO read side.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 fifo_empty_n  input  1  FIFO holds at least one word; fifo_dout is valid while high.
REQ-007 fifo_dout  input  DW_IN  FIFO head word.
REQ-008 fifo_re  output  1  pop request; FIFO pops on a clk edge where fifo_re & fifo_empty_n.
REQ-009 flush  input  1  synchronous discard of all buffered words and partial slices.
REQ-010 o_valid  output  1  o_data holds a valid slice.
REQ-011 o_ready  input  1  consumer accepts the slice; transfer = o_valid & o_ready.
REQ-012 o_data  output  DW_OUT  current slice.
REQ-013 o_last  output  1  current slice is the final slice of its word.

Function
REQ-014 Word buffer: 2 entries (head, tail), occupancy occ ∈ {0,1,2}, plus slice counter cnt (CW bits) indexing the head.
REQ-015 fifo_re = fifo_empty_n & (occ < 2) & ~flush; no combinational path from o_ready to fifo_re.
REQ-016 Pop (fifo_re & fifo_empty_n) writes fifo_dout into the first free entry at that clk edge.
REQ-017 o_valid = (occ != 0); o_data = head[cnt*DW_OUT +: DW_OUT], slice 0 = LSBs; o_last = (cnt == RATIO-1).
REQ-018 Transfer with o_last=0: cnt increments; head unchanged.
REQ-019 Transfer with o_last=1: cnt returns to 0; head retires; tail (if any) becomes head next cycle.
REQ-020 Simultaneous pop and head retirement: occ unchanged; the new word enters the freed slot, preserving order.
REQ-021 Latency: a word present with occ=0 appears on o_valid exactly 1 cycle after the pop edge.
REQ-022 Throughput: with fifo_empty_n and o_ready held high, one slice transfers every cycle with no bubbles for any RATIO, including RATIO=1.
REQ-023 o_valid high & o_ready low: o_data, o_last and cnt stay stable until the transfer.
REQ-024 RATIO=1: o_last is constantly 1 and cnt is held at 0.
REQ-025 flush high at an edge: occ←0 and cnt←0; no pop occurs in that cycle; any simultaneous transfer is discarded.
REQ-026 Words already in the FIFO are not affected by flush.
REQ-027 fifo_empty_n low: no write; buffered slices continue to drain normally.

Reset
REQ-028 With rstn low: occ=0, cnt=0, buffer contents=0, o_valid=0, o_data=0, o_last=0 (or 1 when RATIO=1), fifo_re=0.
REQ-029 Reset asserted mid-word: partial slices are discarded immediately; output resumes from slice 0 of the next word popped after release.
REQ-030 First pop may occur on the first clk edge after rstn deasserts.

Structure
REQ-031 Shared package x_common_pkg holds the safe-width function (returns max(1, clog2(n))); no block-specific typedefs go into it.
REQ-032 Sub-module x_word_buf2 implements the 2-entry ordered buffer (push, pop, flush, occ, head, tail); x_rd_unpack adds the slice counter and output mux.
REQ-033 All flops share clk and the asynchronous rstn.

Verification (DW_OUT=8, RATIO=4 unless stated)
REQ-034 Bench drives FIFO word 0x44332211, o_ready=1 -> o_data sequence 11,22,33,44 on consecutive cycles; o_last only on 44; exactly one fifo_re pop.
REQ-035 Bench drives 3 words back-to-back, o_ready=1 -> 12 slices with no gaps; occ never exceeds 2; word order preserved.
REQ-036 Bench toggles o_ready 1,0,0,1 on word 0xDDCCBBAA -> AA transfers, BB held stable for 2 cycles, then transfers; no slice lost or duplicated.
REQ-037 Bench asserts flush after slice 22 of 0x44332211 with a second word buffered -> o_valid=0 next cycle; the next word popped starts at slice 0.
REQ-038 RATIO=1 with a stream of 5 words and o_ready=1 -> 5 transfers in 5 consecutive cycles; o_last constantly 1.
REQ-039 Bench asserts rstn low mid-word -> all outputs reach reset values asynchronously; after release the next word starts at slice 0.

Source files
------------

// File: rtl/x_common_pkg.sv
// Shared helpers for the x_* blocks.
// safe_w gives a counter width that never collapses to zero bits.
package x_common_pkg;

    function automatic int safe_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/x_word_buf2.sv
// Two-entry ordered word buffer (head/tail) with synchronous flush.
// Latency: a pushed word is visible at head one cycle after the push edge when empty.
// Backpressure: caller must not push when full; push and pop in one cycle keep occupancy.
module x_word_buf2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] tail;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= push_dat;
                    else             tail <= push_dat;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // New word lands behind whatever survives the retirement.
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= push_dat;
                    end else begin
                        head <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/x_rd_unpack.sv
// Unpacks FIFO words of RATIO slices into a valid/ready stream, slice 0 (LSBs) first.
// Latency: 1 cycle from FIFO pop to first slice valid; one slice per cycle sustained.
// Backpressure: o_ready low holds slice and counter; FIFO reads stop when both buffer entries are full.
module x_rd_unpack
    import x_common_pkg::*;
#(
    parameter int DW_OUT = 8,
    parameter int RATIO  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     fifo_empty_n,
    input  logic [DW_OUT*RATIO-1:0]  fifo_dout,
    output logic                     fifo_re,
    input  logic                     flush,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [DW_OUT-1:0]        o_data,
    output logic                     o_last
);

    localparam int DW_IN = DW_OUT * RATIO;
    localparam int CW    = safe_w(RATIO);
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    logic [1:0]                    occ;
    logic [DW_IN-1:0]              head;
    logic [RATIO-1:0][DW_OUT-1:0]  slices;
    logic [CW-1:0]                 cnt;
    logic                          xfer;
    logic                          retire;

    // Read decision depends only on local state, never on o_ready.
    assign fifo_re = rstn & fifo_empty_n & ~occ[1] & ~flush;

    assign xfer    = o_valid & o_ready;
    assign retire  = xfer & o_last;

    x_word_buf2 #(
        .W (DW_IN)
    ) u_buf (
        .clk      (clk),
        .rstn     (rstn),
        .push     (fifo_re),
        .push_dat (fifo_dout),
        .pop      (retire),
        .flush    (flush),
        .occ      (occ),
        .head     (head)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                cnt <= '0;
        else if (flush || retire) cnt <= '0;
        else if (xfer)            cnt <= cnt + 1'b1;
    end

    assign slices  = head;
    assign o_valid = (occ != 2'd0);
    assign o_data  = slices[cnt];
    assign o_last  = (cnt == LAST_IDX);

endmodule

// File: tb/tb_x_rd_unpack.sv
// Directed bench for x_rd_unpack: RATIO=4 vector table plus a RATIO=1 streaming sequence.
module tb_x_rd_unpack;

    logic        clk;
    logic        rstn;

    logic        en4, re4, flush4, vld4, rdy4, last4;
    logic [31:0] dout4;
    logic [7:0]  dat4;

    logic        en1, re1, flush1, vld1, rdy1, last1;
    logic [7:0]  dout1;
    logic [7:0]  dat1;

    int total = 0;
    int bad   = 0;
    int pops4 = 0;

    logic [31:0] q4[$];
    logic [7:0]  q1[$];

    typedef struct {
        logic        rst;
        logic        push;
        logic [31:0] word;
        logic        rdy;
        logic        fl;
        logic        vld;
        logic [7:0]  dat;
        logic        last;
        logic        re;
    } vec_t;

    vec_t tbl[$];

    x_rd_unpack #(.DW_OUT(8), .RATIO(4)) u_dut4 (
        .clk          (clk),
        .rstn         (rstn),
        .fifo_empty_n (en4),
        .fifo_dout    (dout4),
        .fifo_re      (re4),
        .flush        (flush4),
        .o_valid      (vld4),
        .o_ready      (rdy4),
        .o_data       (dat4),
        .o_last       (last4)
    );

    x_rd_unpack #(.DW_OUT(8), .RATIO(1)) u_dut1 (
        .clk          (clk),
        .rstn         (rstn),
        .fifo_empty_n (en1),
        .fifo_dout    (dout1),
        .fifo_re      (re1),
        .flush        (flush1),
        .o_valid      (vld1),
        .o_ready      (rdy1),
        .o_data       (dat1),
        .o_last       (last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic push, input logic [31:0] word,
                       input logic rdy, input logic fl, input logic vld,
                       input logic [7:0] dat, input logic last, input logic re);
        vec_t v;
        v.rst = rst; v.push = push; v.word = word; v.rdy = rdy; v.fl = fl;
        v.vld = vld; v.dat = dat; v.last = last; v.re = re;
        tbl.push_back(v);
    endtask

    initial begin
        logic pop;
        vec_t v;

        rstn = 1'b0;
        en4 = 1'b0; dout4 = '0; flush4 = 1'b0; rdy4 = 1'b0;
        en1 = 1'b0; dout1 = '0; flush1 = 1'b0; rdy1 = 1'b0;

        // reset
        add(1, 0, 32'h0,        0, 0,  0, 8'h00, 0, 0);
        // single word, free-running consumer
        add(0, 1, 32'h44332211, 1, 0,  0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        1, 0,  1, 8'h11, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h22, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h33, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h44, 1, 0);
        add(0, 0, 32'h0,        1, 0,  0, 8'h00, 0, 0);
        // three words back to back
        add(0, 1, 32'h04030201, 1, 0,  0, 8'h00, 0, 1);
        add(0, 1, 32'h08070605, 1, 0,  1, 8'h01, 0, 1);
        add(0, 1, 32'h0C0B0A09, 1, 0,  1, 8'h02, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h03, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h04, 1, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h05, 0, 1);
        add(0, 0, 32'h0,        1, 0,  1, 8'h06, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h07, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h08, 1, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h09, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h0A, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h0B, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h0C, 1, 0);
        add(0, 0, 32'h0,        1, 0,  0, 8'h00, 0, 0);
        // consumer stall 1,0,0,1
        add(0, 1, 32'hDDCCBBAA, 1, 0,  0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        1, 0,  1, 8'hAA, 0, 0);
        add(0, 0, 32'h0,        0, 0,  1, 8'hBB, 0, 0);
        add(0, 0, 32'h0,        0, 0,  1, 8'hBB, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'hBB, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'hCC, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'hDD, 1, 0);
        add(0, 0, 32'h0,        1, 0,  0, 8'h00, 0, 0);
        // flush after slice 22 with second word buffered; third word stays in FIFO
        add(0, 1, 32'h44332211, 1, 0,  0, 8'h00, 0, 1);
        add(0, 1, 32'h88776655, 1, 0,  1, 8'h11, 0, 1);
        add(0, 1, 32'hCCBBAA99, 1, 0,  1, 8'h22, 0, 0);
        add(0, 0, 32'h0,        1, 1,  1, 8'h33, 0, 0);
        add(0, 0, 32'h0,        1, 0,  0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        1, 0,  1, 8'h99, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'hAA, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'hBB, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'hCC, 1, 0);
        add(0, 0, 32'h0,        1, 0,  0, 8'h00, 0, 0);
        // reset mid-word while the FIFO holds the next word
        add(0, 1, 32'h44332211, 1, 0,  0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        1, 0,  1, 8'h11, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h22, 0, 0);
        add(1, 1, 32'h88776655, 1, 0,  0, 8'h00, 0, 0);
        add(0, 0, 32'h0,        1, 0,  0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        1, 0,  1, 8'h55, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h66, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h77, 0, 0);
        add(0, 0, 32'h0,        1, 0,  1, 8'h88, 1, 0);
        add(0, 0, 32'h0,        1, 0,  0, 8'h00, 0, 0);

        @(negedge clk);
        chk("r1 reset last", {31'd0, last1}, 32'd1);
        chk("r1 reset vld",  {31'd0, vld1},  32'd0);
        chk("r1 reset re",   {31'd0, re1},   32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            rstn   = ~v.rst;
            if (v.push) q4.push_back(v.word);
            rdy4   = v.rdy;
            flush4 = v.fl;
            en4    = (q4.size() != 0);
            dout4  = (q4.size() != 0) ? q4[0] : 32'h0;
            @(negedge clk);
            chk($sformatf("row%0d vld", i),  {31'd0, vld4},  {31'd0, v.vld});
            chk($sformatf("row%0d last", i), {31'd0, last4}, {31'd0, v.last});
            chk($sformatf("row%0d re", i),   {31'd0, re4},   {31'd0, v.re});
            if (v.vld || v.rst)
                chk($sformatf("row%0d dat", i), {24'd0, dat4}, {24'd0, v.dat});
            pop = re4 & en4;
            @(posedge clk);
            #1;
            if (pop) begin
                void'(q4.pop_front());
                pops4++;
            end
        end
        chk("r4 pop count", pops4, 10);
        chk("r4 fifo left", q4.size(), 0);

        // RATIO=1: five words stream one per cycle
        en4 = 1'b0; rdy4 = 1'b0;
        for (int w = 1; w <= 5; w++) q1.push_back(8'(w * 16));
        for (int c = 0; c < 7; c++) begin
            rdy1  = 1'b1;
            en1   = (q1.size() != 0);
            dout1 = (q1.size() != 0) ? q1[0] : 8'h00;
            @(negedge clk);
            chk($sformatf("r1 c%0d last", c), {31'd0, last1}, 32'd1);
            chk($sformatf("r1 c%0d vld", c),  {31'd0, vld1},
                (c >= 1 && c <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("r1 c%0d re", c),   {31'd0, re1},
                (c <= 4) ? 32'd1 : 32'd0);
            if (c >= 1 && c <= 5)
                chk($sformatf("r1 c%0d dat", c), {24'd0, dat1}, 32'(c * 16));
            pop = re1 & en1;
            @(posedge clk);
            #1;
            if (pop) void'(q1.pop_front());
        end
        chk("r1 fifo left", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
